// File: rtl/intt_pkg.sv
// Shared definitions for the inverse-NTT scheduler family.
// Holds FSM state encodings, default transform size and modulus constants.
package intt_pkg;

  // Scheduler states; SCALE is only reachable when INTT_SCALE_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BFLY  = 3'd1,
    DRAIN = 3'd2,
    SCALE = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int LOG_N_DEF = 3;
  localparam int Q         = 257;
  // n^-1 mod q for N=8, q=257: 8 * 225 = 1800 = 7*257 + 1.
  localparam int N_INV     = 225;

  // Bits needed to hold a stage index 0..log_n-1.
  function automatic int s_width(input int log_n);
    return (log_n > 2) ? $clog2(log_n) : 1;
  endfunction

endpackage

// File: rtl/intt_bfly_addr_gen.sv
// Combinational Gentleman-Sande butterfly address generator.
// For stage s and butterfly k: t = 2^s, h = N >> (s+1), i = k >> s,
// j = (i << (s+1)) + (k & (t-1)); a = j, b = j+t, tw = h+i.
// Shared with the forward-NTT scheduler.
module intt_bfly_addr_gen
  import intt_pkg::*;
#(
  parameter int LOG_N = LOG_N_DEF,
  localparam int SW   = s_width(LOG_N)
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG_N-2:0] k,
  output logic [LOG_N-1:0] bf_addr_a,
  output logic [LOG_N-1:0] bf_addr_b,
  output logic [LOG_N-1:0] tw_addr
);

  logic [LOG_N-1:0] kx;
  logic [LOG_N-1:0] t;
  logic [LOG_N-1:0] h;
  logic [LOG_N-1:0] i;
  logic [LOG_N-1:0] lo;
  logic [LOG_N-1:0] j;
  logic [SW-1:0]    hsh;

  // Address arithmetic; h is formed as 1 << (LOG_N-1-s) to stay within LOG_N bits.
  always_comb begin
    kx        = {1'b0, k};
    t         = LOG_N'(1) << s;
    hsh       = SW'(LOG_N - 1) - s;
    h         = LOG_N'(1) << hsh;
    i         = kx >> s;
    lo        = kx & (t - LOG_N'(1));
    j         = ((i << s) << 1) + lo;
    bf_addr_a = j;
    bf_addr_b = j + t;
    tw_addr   = h + i;
  end

endmodule

// File: rtl/intt_sched_ctrl.sv
// In-place Gentleman-Sande inverse-NTT scheduler.
// Issues one butterfly address triple per handshake, drains the datapath
// for BF_LAT cycles between stages, then pulses done.
// Optional macro INTT_SCALE_EN adds a SCALE pass issuing addresses 0..N-1
// for the n^-1 multiply, followed by one more drain.
module intt_sched_ctrl
  import intt_pkg::*;
#(
  parameter int LOG_N  = LOG_N_DEF,
  parameter int BF_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             bf_valid,
  input  logic             bf_ready,
  output logic [LOG_N-1:0] bf_addr_a,
  output logic [LOG_N-1:0] bf_addr_b,
  output logic [LOG_N-1:0] tw_addr,
`ifdef INTT_SCALE_EN
  output logic             sc_valid,
  input  logic             sc_ready,
  output logic [LOG_N-1:0] sc_addr,
`endif
  output logic             bf_last
);

  localparam int SW = s_width(LOG_N);
  localparam int KW = LOG_N - 1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [3:0]    D_LAST = 4'(BF_LAT - 1);

  state_t           state;
  state_t           state_nx;
  logic [SW-1:0]    s;
  logic [KW-1:0]    k;
  logic [3:0]       dcnt;
  logic             bf_hs;
  logic [LOG_N-1:0] gen_a;
  logic [LOG_N-1:0] gen_b;
  logic [LOG_N-1:0] gen_tw;

`ifdef INTT_SCALE_EN
  localparam logic [LOG_N-1:0] SC_LAST = '1;
  logic [LOG_N-1:0] sc_cnt;
  logic             sc_done;
  logic             sc_hs;
  assign sc_hs = (state == SCALE) & sc_ready;
`endif

  assign bf_hs = (state == BFLY) & bf_ready;

  intt_bfly_addr_gen #(
    .LOG_N (LOG_N)
  ) u_addr_gen (
    .s         (s),
    .k         (k),
    .bf_addr_a (gen_a),
    .bf_addr_b (gen_b),
    .tw_addr   (gen_tw)
  );

  // State register; reset aborts any transform in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Stage, butterfly, drain (and scale) counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      k    <= '0;
      dcnt <= '0;
`ifdef INTT_SCALE_EN
      sc_cnt  <= '0;
      sc_done <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s    <= '0;
            k    <= '0;
            dcnt <= '0;
          end
        end
        BFLY: begin
          if (bf_hs) begin
            if (k == K_LAST) k <= '0;
            else             k <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) begin
            dcnt <= '0;
            if (s != S_LAST) s <= s + 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
`ifdef INTT_SCALE_EN
        SCALE: begin
          if (sc_hs) begin
            if (sc_cnt == SC_LAST) begin
              sc_cnt  <= '0;
              sc_done <= 1'b1;
            end else begin
              sc_cnt <= sc_cnt + 1'b1;
            end
          end
        end
`endif
        FIN: begin
          s <= '0;
`ifdef INTT_SCALE_EN
          sc_done <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Next-state and outputs; addresses are forced to 0 whenever not issuing.
  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    done      = (state == FIN);
    bf_valid  = (state == BFLY);
    bf_addr_a = '0;
    bf_addr_b = '0;
    tw_addr   = '0;
    bf_last   = 1'b0;
`ifdef INTT_SCALE_EN
    sc_valid  = (state == SCALE);
    sc_addr   = (state == SCALE) ? sc_cnt : '0;
`endif
    if (state == BFLY) begin
      bf_addr_a = gen_a;
      bf_addr_b = gen_b;
      tw_addr   = gen_tw;
      bf_last   = (s == S_LAST) && (k == K_LAST);
    end
    case (state)
      IDLE:  if (start) state_nx = BFLY;
      BFLY:  if (bf_hs && (k == K_LAST)) state_nx = DRAIN;
      DRAIN: begin
        if (dcnt == D_LAST) begin
          if (s != S_LAST) state_nx = BFLY;
`ifdef INTT_SCALE_EN
          else if (!sc_done) state_nx = SCALE;
`endif
          else state_nx = FIN;
        end
      end
`ifdef INTT_SCALE_EN
      SCALE: if (sc_hs && (sc_cnt == SC_LAST)) state_nx = DRAIN;
`endif
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_intt_sched_ctrl.sv
// Directed testbench for intt_sched_ctrl (N=8, BF_LAT=4).
// Cycle c is the interval after clock edge c-1, where edge 0 samples start.
module tb_intt_sched_ctrl;

  localparam int LOG_N  = 3;
  localparam int BF_LAT = 4;
`ifdef INTT_SCALE_EN
  localparam int DONE_C = 37;
`else
  localparam int DONE_C = 25;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       bf_valid;
  logic       bf_ready;
  logic [2:0] bf_addr_a;
  logic [2:0] bf_addr_b;
  logic [2:0] tw_addr;
  logic       bf_last;
  logic       sc_ready;
`ifdef INTT_SCALE_EN
  logic       sc_valid;
  logic [2:0] sc_addr;
`endif

  intt_sched_ctrl #(
    .LOG_N  (LOG_N),
    .BF_LAT (BF_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bf_valid  (bf_valid),
    .bf_ready  (bf_ready),
    .bf_addr_a (bf_addr_a),
    .bf_addr_b (bf_addr_b),
    .tw_addr   (tw_addr),
`ifdef INTT_SCALE_EN
    .sc_valid  (sc_valid),
    .sc_ready  (sc_ready),
    .sc_addr   (sc_addr),
`endif
    .bf_last   (bf_last)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw [12] = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};

  int ha [128];
  int hb [128];
  int htw[128];
  bit hv [128];
  bit hbusy[128];
  bit hdone[128];
  bit hlast[128];
  int iss_a[64];
  int iss_b[64];
  int iss_tw[64];
  int iss_cyc[64];
  bit iss_last[64];
  int n_iss, done_cnt, done_cyc, done_cyc2;
  int sc_a[32];
  int sc_c[32];
  int n_sc;

  // Start a transform at edge 0 and record ncyc cycles of activity.
  task automatic run_seq(input int stall_at, input int stall_n, input int pulse_at,
                         input int rst_at, input int rst_n, input int ncyc);
    n_iss = 0; done_cnt = 0; done_cyc = -1; done_cyc2 = -1; n_sc = 0;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; bf_ready = 1'b1; sc_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start    = (c == pulse_at);
      bf_ready = !(c >= stall_at && c < stall_at + stall_n);
      rst      = (c >= rst_at && c < rst_at + rst_n);
      #1;
      ha[c] = bf_addr_a; hb[c] = bf_addr_b; htw[c] = tw_addr;
      hv[c] = bf_valid; hbusy[c] = busy; hdone[c] = done; hlast[c] = bf_last;
      if (bf_valid && bf_ready && n_iss < 64) begin
        iss_a[n_iss] = bf_addr_a; iss_b[n_iss] = bf_addr_b; iss_tw[n_iss] = tw_addr;
        iss_cyc[n_iss] = c; iss_last[n_iss] = bf_last;
        n_iss++;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = c;
        else done_cyc2 = c;
      end
`ifdef INTT_SCALE_EN
      if (sc_valid && sc_ready && n_sc < 32) begin
        sc_a[n_sc] = sc_addr; sc_c[n_sc] = c; n_sc++;
      end
`endif
    end
    start = 1'b0; bf_ready = 1'b1; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bf_ready = 1'b1; sc_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", busy, done);
    end
    tests++;
    if (bf_valid !== 1'b0 || bf_last !== 1'b0) begin
      fails++; $display("FAIL reset_valid: bf_valid=%b bf_last=%b expected 0 0", bf_valid, bf_last);
    end
    tests++;
    if ({bf_addr_a, bf_addr_b, tw_addr} !== 9'd0) begin
      fails++; $display("FAIL reset_addr: got (%0d,%0d,%0d) expected (0,0,0)", bf_addr_a, bf_addr_b, tw_addr);
    end
    start = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_start_ignored: busy=%b expected 0", busy);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    int nlast;
    run_seq(0, 0, 0, 0, 0, DONE_C + 3);
    tests++;
    if (n_iss !== 12) begin
      fails++; $display("FAIL seq_count: got %0d issues expected 12", n_iss);
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (iss_a[i] !== exp_a[i] || iss_b[i] !== exp_b[i] || iss_tw[i] !== exp_tw[i]) begin
        fails++;
        $display("FAIL seq_issue%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", i,
                 iss_a[i], iss_b[i], iss_tw[i], exp_a[i], exp_b[i], exp_tw[i]);
      end
      tests++;
      if (iss_cyc[i] !== 1 + (i / 4) * 8 + (i % 4)) begin
        fails++; $display("FAIL seq_cycle%0d: got %0d expected %0d", i, iss_cyc[i], 1 + (i / 4) * 8 + (i % 4));
      end
      tests++;
      if (iss_last[i] !== (i == 11)) begin
        fails++; $display("FAIL seq_last%0d: got %b expected %b", i, iss_last[i], (i == 11));
      end
    end
    nlast = 0;
    for (int c = 1; c <= DONE_C + 3; c++) if (hlast[c]) nlast++;
    tests++;
    if (nlast !== 1) begin
      fails++; $display("FAIL seq_last_cycles: got %0d expected 1", nlast);
    end
    tests++;
    if (done_cyc !== DONE_C || done_cnt !== 1) begin
      fails++; $display("FAIL seq_done: got cycle %0d count %0d expected cycle %0d count 1", done_cyc, done_cnt, DONE_C);
    end
    tests++;
    if (hbusy[1] !== 1'b1 || hbusy[DONE_C] !== 1'b1 || hbusy[DONE_C + 1] !== 1'b0) begin
      fails++; $display("FAIL seq_busy: got %b%b%b expected 110", hbusy[1], hbusy[DONE_C], hbusy[DONE_C + 1]);
    end
  endtask

  task automatic test_drain();
    run_seq(0, 0, 0, 0, 0, DONE_C + 2);
    for (int c = 1; c <= 24; c++) begin
      tests++;
      if (hv[c] !== (((c - 1) % 8) < 4)) begin
        fails++; $display("FAIL drain_valid_c%0d: got %b expected %b", c, hv[c], (((c - 1) % 8) < 4));
      end
    end
  endtask

  task automatic test_stall();
    int bad;
    run_seq(2, 3, 0, 0, 0, DONE_C + 6);
    for (int c = 2; c <= 4; c++) begin
      tests++;
      if (hv[c] !== 1'b1 || ha[c] !== 2 || hb[c] !== 3 || htw[c] !== 5) begin
        fails++; $display("FAIL stall_hold_c%0d: got v=%b (%0d,%0d,%0d) expected v=1 (2,3,5)", c, hv[c], ha[c], hb[c], htw[c]);
      end
    end
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (iss_a[i] !== exp_a[i] || iss_b[i] !== exp_b[i] || iss_tw[i] !== exp_tw[i]) bad++;
    tests++;
    if (n_iss !== 12 || bad !== 0) begin
      fails++; $display("FAIL stall_seq: got %0d issues %0d wrong expected 12 issues 0 wrong", n_iss, bad);
    end
    tests++;
    if (iss_cyc[1] !== 5) begin
      fails++; $display("FAIL stall_accept: got cycle %0d expected 5", iss_cyc[1]);
    end
    tests++;
    if (done_cyc !== DONE_C + 3) begin
      fails++; $display("FAIL stall_done: got cycle %0d expected %0d", done_cyc, DONE_C + 3);
    end
  endtask

  task automatic test_start_while_busy();
    int late_busy;
    run_seq(0, 0, 10, 0, 0, DONE_C + 8);
    tests++;
    if (done_cnt !== 1 || done_cyc !== DONE_C) begin
      fails++; $display("FAIL busy_start_done: got count %0d cycle %0d expected 1 %0d", done_cnt, done_cyc, DONE_C);
    end
    late_busy = 0;
    for (int c = DONE_C + 1; c <= DONE_C + 8; c++) if (hbusy[c]) late_busy++;
    tests++;
    if (late_busy !== 0 || n_iss !== 12) begin
      fails++; $display("FAIL busy_start_restart: got %0d busy cycles %0d issues expected 0 12", late_busy, n_iss);
    end
  endtask

  task automatic test_abort_reset();
    int late_busy;
    run_seq(0, 0, 0, 14, 2, 24);
    for (int c = 14; c <= 15; c++) begin
      tests++;
      if (hbusy[c] !== 1'b0 || hv[c] !== 1'b0 || hdone[c] !== 1'b0 || ha[c] !== 0 || hb[c] !== 0 || htw[c] !== 0) begin
        fails++; $display("FAIL abort_outputs_c%0d: got busy=%b v=%b done=%b (%0d,%0d,%0d) expected all 0",
                          c, hbusy[c], hv[c], hdone[c], ha[c], hb[c], htw[c]);
      end
    end
    late_busy = 0;
    for (int c = 16; c <= 24; c++) if (hbusy[c]) late_busy++;
    tests++;
    if (done_cnt !== 0 || late_busy !== 0 || n_iss !== 8) begin
      fails++; $display("FAIL abort_quiet: got done=%0d busy=%0d issues=%0d expected 0 0 8", done_cnt, late_busy, n_iss);
    end
    run_seq(0, 0, 0, 0, 0, DONE_C + 2);
    tests++;
    if (iss_a[0] !== 0 || iss_b[0] !== 1 || iss_tw[0] !== 4 || n_iss !== 12) begin
      fails++; $display("FAIL abort_restart: got (%0d,%0d,%0d) n=%0d expected (0,1,4) n=12", iss_a[0], iss_b[0], iss_tw[0], n_iss);
    end
    tests++;
    if (done_cyc !== DONE_C) begin
      fails++; $display("FAIL abort_restart_done: got cycle %0d expected %0d", done_cyc, DONE_C);
    end
  endtask

  task automatic test_back_to_back();
    run_seq(0, 0, DONE_C + 1, 0, 0, 2 * DONE_C + 4);
    tests++;
    if (done_cnt !== 2 || done_cyc2 !== 2 * DONE_C + 1) begin
      fails++; $display("FAIL b2b_done: got count %0d second %0d expected 2 %0d", done_cnt, done_cyc2, 2 * DONE_C + 1);
    end
    tests++;
    if (n_iss !== 24 || iss_a[12] !== 0 || iss_b[12] !== 1 || iss_tw[12] !== 4 || iss_cyc[12] !== DONE_C + 2) begin
      fails++; $display("FAIL b2b_issue: got n=%0d (%0d,%0d,%0d) at %0d expected n=24 (0,1,4) at %0d",
                        n_iss, iss_a[12], iss_b[12], iss_tw[12], iss_cyc[12], DONE_C + 2);
    end
  endtask

`ifdef INTT_SCALE_EN
  task automatic test_scale();
    run_seq(0, 0, 0, 0, 0, DONE_C + 2);
    tests++;
    if (n_sc !== 8) begin
      fails++; $display("FAIL scale_count: got %0d expected 8", n_sc);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (sc_a[i] !== i || sc_c[i] !== 25 + i) begin
        fails++; $display("FAIL scale_addr%0d: got %0d at %0d expected %0d at %0d", i, sc_a[i], sc_c[i], i, 25 + i);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; bf_ready = 1'b1; sc_ready = 1'b1;
    test_reset();
    test_sequence();
    test_drain();
    test_stall();
    test_start_while_busy();
    test_abort_reset();
    test_back_to_back();
`ifdef INTT_SCALE_EN
    test_scale();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
